// File: rtl/eeprom_pgm_pkg.sv
// Shared constants for the eeprom_pgm word store: FSM encodings, default
// geometry and a small sizing helper.
package eeprom_pgm_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROG  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_ERASE = 2'd3;

  // Default geometry and timing
  localparam int unsigned DEF_DW     = 32;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_WR_CYC = 4;
  localparam int unsigned DEF_RD_LAT = 2;

  // Largest of three values, used to size the shared cycle counter
  function automatic int unsigned max3(input int unsigned x,
                                       input int unsigned y,
                                       input int unsigned z);
    int unsigned m;
    m = x;
    if (y > m) m = y;
    if (z > m) m = z;
    return m;
  endfunction

endpackage

// File: rtl/eeprom_pgm_array.sv
// DEPTH x DW storage: one synchronous write port, one registered read port.
// Contents are deliberately not reset (non-volatile behaviour).
module eeprom_pgm_array #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          c,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  // Write port plus one-cycle registered read; out-of-range reads return zero
  always_ff @(posedge c) begin
    if (we && ({1'b0, wa} < DEPTH_W)) begin
      mem[wa] <= wd;
    end
    if ({1'b0, ra} < DEPTH_W) begin
      rd <= mem[ra];
    end else begin
      rd <= '0;
    end
  end

endmodule

// File: rtl/eeprom_pgm.sv
// EEPROM-like parameter store: multi-cycle program, fixed read latency,
// bulk erase and write protect, with busy/vld/err handshakes for clients.
module eeprom_pgm
  import eeprom_pgm_pkg::*;
#(
  parameter int unsigned   DW        = DEF_DW,
  parameter int unsigned   DEPTH     = DEF_DEPTH,
  parameter int unsigned   AW        = $clog2(DEPTH),
  parameter int unsigned   WR_CYC    = DEF_WR_CYC,
  parameter int unsigned   RD_LAT    = DEF_RD_LAT,
  parameter logic [DW-1:0] ERASE_VAL = '1
) (
  input  logic          c,
  input  logic          rst,
  input  logic          str,
  input  logic          ld,
  input  logic          clr,
  input  logic          wp,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d,
  output logic          busy,
  output logic          vld,
  output logic          err
);

  // The array's registered read port takes one cycle before d can load,
  // so the shortest read served is two cycles.
  localparam int unsigned WR_EFF = (WR_CYC < 1) ? 1 : WR_CYC;
  localparam int unsigned RD_EFF = (RD_LAT < 2) ? 2 : RD_LAT;
  localparam int unsigned CW     = $clog2(max3(WR_EFF, RD_EFF, DEPTH) + 1);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_EFF - 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_EFF - 2);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_EFF - 1);
  localparam logic [AW-1:0] EA_LAST = AW'(DEPTH - 1);

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] ea, ea_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] data_q, data_n;
  logic [DW-1:0] d_n;
  logic          busy_n, vld_n, err_n;

  logic          req_any_c, multi_c, a_ok_c, accept_c;
  logic          we_c;
  logic [AW-1:0] wa_c, ra_c;
  logic [DW-1:0] wd_c, rd_c;

  // Request decode shared by all states
  assign req_any_c = str | ld | clr;
  assign multi_c   = (clr & (str | ld)) | (str & ld);
  assign a_ok_c    = ({1'b0, a} < DEPTH_W);

  // Storage; a reset in the final program/erase cycle suppresses that write
  eeprom_pgm_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .c  (c),
    .we (we_c & ~rst),
    .wa (wa_c),
    .wd (wd_c),
    .ra (ra_c),
    .rd (rd_c)
  );

  // State and output registers
  always_ff @(posedge c) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ea     <= '0;
      addr_q <= '0;
      data_q <= '0;
      d      <= '0;
      busy   <= 1'b0;
      vld    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ea     <= ea_n;
      addr_q <= addr_n;
      data_q <= data_n;
      d      <= d_n;
      busy   <= busy_n;
      vld    <= vld_n;
      err    <= err_n;
    end
  end

  // Next-state, array port control and output decode
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ea_n     = ea;
    addr_n   = addr_q;
    data_n   = data_q;
    d_n      = d;
    busy_n   = busy;
    vld_n    = 1'b0;
    err_n    = 1'b0;
    accept_c = 1'b0;
    we_c     = 1'b0;
    wa_c     = addr_q;
    wd_c     = data_q;
    ra_c     = addr_q;

    case (state)
      ST_IDLE: begin
        // Read the live address so a load can start at its accept edge
        ra_c = a;
        if (clr) begin
          if (!wp) begin
            accept_c = 1'b1;
            state_n  = ST_ERASE;
            ea_n     = '0;
            busy_n   = 1'b1;
          end
        end else if (str) begin
          if (!wp && a_ok_c) begin
            accept_c = 1'b1;
            state_n  = ST_PROG;
            addr_n   = a;
            data_n   = d_in;
            cnt_n    = '0;
            busy_n   = 1'b1;
          end
        end else if (ld) begin
          if (a_ok_c) begin
            accept_c = 1'b1;
            state_n  = ST_READ;
            addr_n   = a;
            cnt_n    = '0;
            busy_n   = 1'b1;
          end
        end
        err_n = req_any_c & (~accept_c | multi_c);
      end

      ST_PROG: begin
        err_n = req_any_c;
        if (cnt == WR_LAST) begin
          we_c    = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_READ: begin
        err_n = req_any_c;
        if (cnt == RD_LOAD) begin
          d_n   = rd_c;
          vld_n = 1'b1;
        end
        if (cnt == RD_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_ERASE: begin
        err_n = req_any_c;
        we_c  = 1'b1;
        wa_c  = ea;
        wd_c  = ERASE_VAL;
        if (ea == EA_LAST) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end else begin
          ea_n = ea + AW'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_eeprom_pgm.sv
// Randomized self-checking bench for eeprom_pgm against a transaction-level
// model of the store (word array, last read value, operation durations).
module tb_eeprom_pgm;

  localparam int DEPTH  = 16;
  localparam int WR_CYC = 4;
  localparam int RD_LAT = 2;
  localparam logic [31:0] ERASE = 32'hFFFF_FFFF;

  logic        c, rst, str, ld, clr, wp;
  logic [3:0]  a;
  logic [31:0] d_in, d;
  logic        busy, vld, err;

  logic        str12, ld12, clr12, wp12;
  logic [3:0]  a12;
  logic [31:0] d_in12, d12;
  logic        busy12, vld12, err12;

  int total, bad;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] d_m;

  eeprom_pgm u_dut (
    .c(c), .rst(rst), .str(str), .ld(ld), .clr(clr), .wp(wp),
    .a(a), .d_in(d_in), .d(d), .busy(busy), .vld(vld), .err(err)
  );

  eeprom_pgm #(.DEPTH(12)) u_dut12 (
    .c(c), .rst(rst), .str(str12), .ld(ld12), .clr(clr12), .wp(wp12),
    .a(a12), .d_in(d_in12), .d(d12), .busy(busy12), .vld(vld12), .err(err12)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Issue one request set in IDLE, follow it cycle by cycle, update the model.
  // poke_sel != 0 injects a request while busy; it must be rejected.
  task automatic do_op(input logic s, input logic l, input logic cl, input logic w,
                       input logic [3:0] addr, input logic [31:0] din,
                       input int poke_sel, input logic [3:0] poke_a);
    int nreq, exp_busy, poke_at;
    logic acc, rej, rd_acc;
    logic [31:0] d_new;
    nreq = int'(s) + int'(l) + int'(cl);
    if (cl)     acc = !w;
    else if (s) acc = !w;
    else        acc = l;
    exp_busy = !acc ? 0 : (cl ? DEPTH : (s ? WR_CYC : RD_LAT));
    rej      = (nreq > 0) && (!acc || nreq > 1);
    rd_acc   = acc && l && !s && !cl;
    d_new    = mem_m[addr];
    poke_at  = (poke_sel != 0 && exp_busy >= 2) ? 1 + (poke_sel % (exp_busy - 1)) : 0;

    str = s; ld = l; clr = cl; wp = w; a = addr; d_in = din;
    @(posedge c); #1;
    str = 1'b0; ld = 1'b0; clr = 1'b0;
    a = 4'($urandom); d_in = $urandom; wp = 1'($urandom);
    for (int k = 1; k <= exp_busy + 1; k++) begin
      if (rd_acc && k == RD_LAT) d_m = d_new;
      check("busy", 32'(busy), 32'(k <= exp_busy));
      check("err",  32'(err),  32'((k == 1 && rej) || (poke_at > 0 && k == poke_at + 1)));
      check("vld",  32'(vld),  32'(rd_acc && k == RD_LAT));
      check("d",    d,         d_m);
      if (k == poke_at) begin
        str = 1'b1; ld = 1'b1; clr = 1'($urandom); a = poke_a; d_in = $urandom;
      end
      if (k <= exp_busy) begin
        @(posedge c); #1;
        str = 1'b0; ld = 1'b0; clr = 1'b0;
      end
    end
    if (acc && cl) begin
      for (int j = 0; j < DEPTH; j++) mem_m[j] = ERASE;
    end else if (acc && s) begin
      mem_m[addr] = din;
    end
  endtask

  // Start an operation (0=program, 1=erase, 2=read) and reset it after r busy cycles.
  task automatic do_rst(input int kind, input logic [3:0] addr, input logic [31:0] din, input int r);
    str = (kind == 0); clr = (kind == 1); ld = (kind == 2);
    wp = 1'b0; a = addr; d_in = din;
    @(posedge c); #1;
    str = 1'b0; ld = 1'b0; clr = 1'b0;
    for (int k = 1; k <= r; k++) begin
      check("rst_busy_pre", 32'(busy), 32'd1);
      if (k < r) begin
        @(posedge c); #1;
      end
    end
    rst = 1'b1;
    @(posedge c); #1;
    rst = 1'b0;
    if (kind == 1) begin
      for (int j = 0; j < r - 1; j++) mem_m[j] = ERASE;
    end
    d_m = 32'h0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_d",    d,         32'h0);
    check("rst_vld",  32'(vld),  32'd0);
    check("rst_err",  32'(err),  32'd0);
  endtask

  initial begin
    int dur;
    logic s, l, cl, w;
    total = 0; bad = 0;
    rst = 1'b1; str = 1'b0; ld = 1'b0; clr = 1'b0; wp = 1'b0; a = '0; d_in = '0;
    str12 = 1'b0; ld12 = 1'b0; clr12 = 1'b0; wp12 = 1'b0; a12 = '0; d_in12 = '0;
    for (int j = 0; j < DEPTH; j++) mem_m[j] = 32'h0;
    d_m = 32'h0;
    repeat (3) @(posedge c);
    #1;
    check("reset_d",    d,          32'h0);
    check("reset_busy", 32'(busy),  32'd0);
    check("reset_vld",  32'(vld),   32'd0);
    check("reset_err",  32'(err),   32'd0);
    check("reset_busy12", 32'(busy12), 32'd0);
    rst = 1'b0;

    // Fill every word with i+1
    for (int i = 0; i < DEPTH; i++) do_op(1, 0, 0, 0, 4'(i), 32'(i + 1), 0, 4'd0);
    // Program then read back
    do_op(1, 0, 0, 0, 4'd3, 32'hDEAD_BEEF, 0, 4'd0);
    do_op(0, 1, 0, 0, 4'd3, 32'h0, 0, 4'd0);
    check("t1_d", d, 32'hDEAD_BEEF);
    // Write-protected program is rejected
    do_op(1, 0, 0, 1, 4'd5, 32'h1234, 0, 4'd0);
    do_op(0, 1, 0, 0, 4'd5, 32'h0, 0, 4'd0);
    check("t2_d", d, 32'h6);
    // Requests during a program are rejected
    do_op(1, 0, 0, 0, 4'd7, 32'h7777_0007, 1, 4'd8);
    do_op(0, 1, 0, 0, 4'd8, 32'h0, 0, 4'd0);
    check("t3_d8", d, 32'h9);
    do_op(0, 1, 0, 0, 4'd7, 32'h0, 0, 4'd0);
    check("t3_d7", d, 32'h7777_0007);
    // Bulk erase, then protected erase keeps refilled values
    do_op(0, 0, 1, 0, 4'd0, 32'h0, 0, 4'd0);
    do_op(0, 1, 0, 0, 4'd15, 32'h0, 0, 4'd0);
    check("t4_erase", d, ERASE);
    for (int i = 0; i < DEPTH; i++) do_op(1, 0, 0, 0, 4'(i), 32'(i + 1), 0, 4'd0);
    do_op(0, 0, 1, 1, 4'd0, 32'h0, 0, 4'd0);
    do_op(0, 1, 0, 0, 4'd9, 32'h0, 0, 4'd0);
    check("t4_wp", d, 32'hA);
    // Reset two cycles into a program leaves the old word
    do_rst(0, 4'd2, 32'hAA, 2);
    do_op(0, 1, 0, 0, 4'd2, 32'h0, 0, 4'd0);
    check("t5_d", d, 32'h3);
    // Simultaneous requests: erase wins, one err pulse
    do_op(1, 1, 1, 0, 4'd4, 32'h5555, 0, 4'd0);

    // Randomized traffic with occasional mid-operation resets
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        dur = $urandom_range(0, 2);
        do_rst(dur, 4'($urandom), $urandom,
               $urandom_range(1, (dur == 0) ? WR_CYC : ((dur == 1) ? DEPTH : RD_LAT)));
      end else begin
        cl = ($urandom_range(0, 9) == 0);
        s  = ($urandom_range(0, 2) == 0);
        l  = ($urandom_range(0, 1) == 0);
        w  = ($urandom_range(0, 3) == 0);
        do_op(s, l, cl, w, 4'($urandom), $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 100)) : 0, 4'($urandom));
      end
    end
    // Final sweep over every word
    for (int i = 0; i < DEPTH; i++) do_op(0, 1, 0, 0, 4'(i), 32'h0, 0, 4'd0);

    // DEPTH=12 instance: out-of-range addresses are rejected
    str12 = 1'b1; a12 = 4'd11; d_in12 = 32'hCAFE_0011;
    @(posedge c); #1;
    str12 = 1'b0;
    check("d12_busy", 32'(busy12), 32'd1);
    repeat (WR_CYC) @(posedge c);
    #1;
    check("d12_idle", 32'(busy12), 32'd0);
    ld12 = 1'b1; a12 = 4'd13;
    @(posedge c); #1;
    ld12 = 1'b0;
    check("d12_ld_err",  32'(err12),  32'd1);
    check("d12_ld_busy", 32'(busy12), 32'd0);
    check("d12_ld_vld",  32'(vld12),  32'd0);
    @(posedge c); #1;
    check("d12_ld_vld2", 32'(vld12),  32'd0);
    check("d12_err_end", 32'(err12),  32'd0);
    str12 = 1'b1; a12 = 4'd12; d_in12 = 32'h1;
    @(posedge c); #1;
    str12 = 1'b0;
    check("d12_st_err",  32'(err12),  32'd1);
    check("d12_st_busy", 32'(busy12), 32'd0);
    ld12 = 1'b1; a12 = 4'd11;
    @(posedge c); #1;
    ld12 = 1'b0;
    @(posedge c); #1;
    check("d12_rd_vld", 32'(vld12), 32'd1);
    check("d12_rd_d",   d12,        32'hCAFE_0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
